// File: rtl/ahb_core_bridge_mux.sv
// ahb_core_bridge_mux: core load/store to AHB-Lite SINGLE bridge with address-decoded slave fan-out,
// default slave, alignment checks and data-phase timeout.
module ahb_core_bridge_mux #(
    parameter int slave_c = 4,
    parameter logic [slave_c*32-1:0] addr_base = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [slave_c*32-1:0] addr_mask = {4{32'hF000_0000}},
    parameter int timeout_c = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    output logic [slave_c*32-1:0]  haddr_s,
    output logic [slave_c*32-1:0]  hwdata_s,
    input  logic [slave_c*32-1:0]  hrdata_s,
    output logic [slave_c-1:0]     hwrite_s,
    output logic [slave_c*2-1:0]   htrans_s,
    output logic [slave_c*3-1:0]   hsize_s,
    output logic [slave_c*3-1:0]   hburst_s,
    input  logic [slave_c*2-1:0]   hresp_s,
    input  logic [slave_c-1:0]     hready_s,
    output logic [slave_c-1:0]     hsel_s,
    input  logic [31:0]            addr,
    input  logic [31:0]            wd,
    output logic [31:0]            rd,
    input  logic                   we,
    input  logic [1:0]             size,
    input  logic                   req,
    output logic                   req_ack,
    output logic                   err
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, DERR1, DERR2} state_t;
    localparam int cw = $clog2(timeout_c + 1);
    state_t state;
    logic [cw-1:0] cnt;
    logic [31:0] haddr, hwdata, wd_r, rdata_m;
    logic [1:0] hsize, resp_m;
    logic hwrite, nonseq, ready_m, bad;
    logic [slave_c-1:0] hit;
    // Descending scan so the lowest matching index is the last write and wins.
    always_comb begin
        hit = '0;
        rdata_m = '0;
        resp_m = '0;
        for (int i = slave_c - 1; i >= 0; i--)
            if ((addr & addr_mask[i*32 +: 32]) == addr_base[i*32 +: 32]) begin
                hit = '0;
                hit[i] = 1'b1;
            end
        for (int i = 0; i < slave_c; i++)
            if (hsel_s[i]) begin
                rdata_m = rdata_m | hrdata_s[i*32 +: 32];
                resp_m = resp_m | hresp_s[i*2 +: 2];
            end
        ready_m = |(hready_s & hsel_s);
        bad = size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    end
    for (genvar g = 0; g < slave_c; g++) begin : g_fan
        assign haddr_s[g*32 +: 32] = haddr;
        assign hwdata_s[g*32 +: 32] = hwdata;
        assign hwrite_s[g] = hwrite;
        assign htrans_s[g*2 +: 2] = (nonseq && hsel_s[g]) ? 2'b10 : 2'b00;
        assign hsize_s[g*3 +: 3] = {1'b0, hsize};
    end
    assign hburst_s = '0;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt <= '0;
            haddr <= '0;
            hwdata <= '0;
            wd_r <= '0;
            hsize <= '0;
            hwrite <= 1'b0;
            nonseq <= 1'b0;
            hsel_s <= '0;
            rd <= '0;
            req_ack <= 1'b0;
            err <= 1'b0;
        end else begin
            req_ack <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: if (req && !req_ack) begin
                    if (bad || hit == '0) state <= DERR1;
                    else begin
                        state <= ADDR;
                        hsel_s <= hit;
                        nonseq <= 1'b1;
                        haddr <= addr;
                        hwrite <= we;
                        hsize <= size;
                        wd_r <= wd;
                    end
                end
                ADDR: begin
                    nonseq <= 1'b0;
                    cnt <= '0;
                    if (hwrite) hwdata <= wd_r;
                    state <= DATA;
                end
                DATA: if (ready_m) begin
                    req_ack <= 1'b1;
                    err <= resp_m == 2'b01;
                    if (!hwrite && resp_m != 2'b01) rd <= rdata_m;
                    hsel_s <= '0;
                    state <= IDLE;
                end else if (cnt == cw'(timeout_c - 1)) begin
                    req_ack <= 1'b1;
                    err <= 1'b1;
                    hsel_s <= '0;
                    state <= IDLE;
                end else cnt <= cnt + 1'b1;
                DERR1: state <= DERR2;
                DERR2: begin
                    req_ack <= 1'b1;
                    err <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_core_bridge_mux.sv
// tb_ahb_core_bridge_mux: directed scenarios for the core-to-AHB bridge with hand-computed expectations.
module tb_ahb_core_bridge_mux;
    logic clk = 1'b0, resetn, we, req, req_ack, err;
    logic [127:0] haddr_s, hwdata_s, hrdata_s;
    logic [3:0] hwrite_s, hready_s, hsel_s;
    logic [7:0] htrans_s, hresp_s;
    logic [11:0] hsize_s, hburst_s;
    logic [31:0] addr, wd, rd;
    logic [1:0] size;
    int n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    ahb_core_bridge_mux dut (.clk(clk), .resetn(resetn), .haddr_s(haddr_s), .hwdata_s(hwdata_s),
        .hrdata_s(hrdata_s), .hwrite_s(hwrite_s), .htrans_s(htrans_s), .hsize_s(hsize_s),
        .hburst_s(hburst_s), .hresp_s(hresp_s), .hready_s(hready_s), .hsel_s(hsel_s), .addr(addr),
        .wd(wd), .rd(rd), .we(we), .size(size), .req(req), .req_ack(req_ack), .err(err));
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        resetn = 1'b0; req = 1'b0; addr = '0; wd = '0; we = 1'b0; size = '0;
        hready_s = 4'hF; hrdata_s = '0; hresp_s = '0;
        tick(); tick();
        n_cmp++; if (hsel_s !== 4'h0) begin n_bad++; $display("FAIL rst_hsel got %h exp 0", hsel_s); end
        n_cmp++; if (htrans_s !== 8'h0) begin n_bad++; $display("FAIL rst_htrans got %h exp 0", htrans_s); end
        n_cmp++; if (rd !== 32'h0 || req_ack !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rst_core got rd=%h ack=%b err=%b exp 0", rd, req_ack, err); end
        n_cmp++; if (haddr_s !== '0 || hwdata_s !== '0 || hwrite_s !== 4'h0 || hsize_s !== '0) begin n_bad++; $display("FAIL rst_bus got addr=%h wr=%h exp 0", haddr_s, hwrite_s); end
        resetn = 1'b1;
        tick();
    endtask
    task automatic test_word_read();
        hrdata_s[63:32] = 32'hDEAD_BEEF;
        addr = 32'h1000_0004; size = 2'd2; we = 1'b0; req = 1'b1;
        tick();
        n_cmp++; if (hsel_s !== 4'b0010) begin n_bad++; $display("FAIL rd_hsel got %b exp 0010", hsel_s); end
        n_cmp++; if (htrans_s !== 8'h08) begin n_bad++; $display("FAIL rd_htrans got %h exp 08", htrans_s); end
        n_cmp++; if (haddr_s[63:32] !== 32'h1000_0004 || hsize_s[5:3] !== 3'b010 || hburst_s !== '0) begin n_bad++; $display("FAIL rd_addrphase got a=%h sz=%b exp 10000004 010", haddr_s[63:32], hsize_s[5:3]); end
        tick();
        n_cmp++; if (htrans_s !== 8'h0 || hsel_s !== 4'b0010 || req_ack !== 1'b0) begin n_bad++; $display("FAIL rd_dataphase got tr=%h sel=%b ack=%b exp 00 0010 0", htrans_s, hsel_s, req_ack); end
        tick();
        n_cmp++; if (req_ack !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL rd_ack got ack=%b err=%b exp 1 0", req_ack, err); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data got %h exp DEADBEEF", rd); end
        req = 1'b0;
        tick();
        n_cmp++; if (req_ack !== 1'b0 || hsel_s !== 4'h0) begin n_bad++; $display("FAIL rd_after got ack=%b sel=%b exp 0 0000", req_ack, hsel_s); end
    endtask
    task automatic test_byte_write_stall();
        hready_s = 4'b1011;
        addr = 32'h2000_0003; wd = 32'h0000_00A5; size = 2'd0; we = 1'b1; req = 1'b1;
        tick();
        n_cmp++; if (hsel_s !== 4'b0100 || htrans_s !== 8'h20) begin n_bad++; $display("FAIL wr_addrphase got sel=%b tr=%h exp 0100 20", hsel_s, htrans_s); end
        n_cmp++; if (hsize_s[8:6] !== 3'b000 || hwrite_s !== 4'hF) begin n_bad++; $display("FAIL wr_ctrl got sz=%b wr=%b exp 000 1111", hsize_s[8:6], hwrite_s); end
        tick();
        for (int k = 3; k <= 7; k++) begin
            tick();
            n_cmp++; if (req_ack !== 1'b0 || hwdata_s[95:64] !== 32'hA5) begin n_bad++; $display("FAIL wr_stall%0d got ack=%b wd=%h exp 0 a5", k, req_ack, hwdata_s[95:64]); end
        end
        hready_s = 4'hF;
        tick();
        n_cmp++; if (req_ack !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL wr_ack got ack=%b err=%b exp 1 0", req_ack, err); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_rd_kept got %h exp DEADBEEF", rd); end
        req = 1'b0; we = 1'b0;
        tick();
    endtask
    task automatic test_default_and_align();
        for (int t = 0; t < 2; t++) begin
            addr = (t == 0) ? 32'hF000_0000 : 32'h0000_0002; size = 2'd2; req = 1'b1;
            tick();
            n_cmp++; if (hsel_s !== 4'h0 || htrans_s !== 8'h0 || req_ack !== 1'b0) begin n_bad++; $display("FAIL derr%0d_c1 got sel=%b tr=%h ack=%b exp 0", t, hsel_s, htrans_s, req_ack); end
            tick();
            n_cmp++; if (hsel_s !== 4'h0 || htrans_s !== 8'h0 || req_ack !== 1'b0) begin n_bad++; $display("FAIL derr%0d_c2 got sel=%b tr=%h ack=%b exp 0", t, hsel_s, htrans_s, req_ack); end
            tick();
            n_cmp++; if (req_ack !== 1'b1 || err !== 1'b1 || rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL derr%0d_ack got ack=%b err=%b rd=%h exp 1 1 DEADBEEF", t, req_ack, err, rd); end
            req = 1'b0;
            tick();
        end
    endtask
    task automatic test_timeout();
        int lat;
        hready_s = 4'b1110;
        addr = 32'h0000_0010; size = 2'd2; req = 1'b1;
        lat = 0;
        while (req_ack !== 1'b1 && lat < 40) begin tick(); lat++; end
        n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL to_latency got %0d exp 18", lat); end
        n_cmp++; if (err !== 1'b1 || hsel_s !== 4'h0) begin n_bad++; $display("FAIL to_err got err=%b sel=%b exp 1 0000", err, hsel_s); end
        req = 1'b0; hready_s = 4'hF; hrdata_s[31:0] = 32'h0BAD_0BAD;
        tick();
        n_cmp++; if (rd !== 32'hDEAD_BEEF || req_ack !== 1'b0) begin n_bad++; $display("FAIL to_late got rd=%h ack=%b exp DEADBEEF 0", rd, req_ack); end
    endtask
    task automatic test_back_to_back();
        hrdata_s[127:96] = 32'hCAFE_F00D; hrdata_s[63:32] = 32'h1234_5678;
        addr = 32'h3000_0008; size = 2'd2; req = 1'b1;
        tick();
        n_cmp++; if (hsel_s !== 4'b1000 || htrans_s !== 8'h80) begin n_bad++; $display("FAIL s3_addrphase got sel=%b tr=%h exp 1000 80", hsel_s, htrans_s); end
        tick(); tick();
        n_cmp++; if (req_ack !== 1'b1 || err !== 1'b0 || rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL s3_ack got ack=%b err=%b rd=%h exp 1 0 CAFEF00D", req_ack, err, rd); end
        addr = 32'h1000_0000;
        tick();
        n_cmp++; if (req_ack !== 1'b0 || hsel_s !== 4'h0) begin n_bad++; $display("FAIL b2b_gap got ack=%b sel=%b exp 0 0000", req_ack, hsel_s); end
        tick();
        n_cmp++; if (hsel_s !== 4'b0010 || htrans_s !== 8'h08) begin n_bad++; $display("FAIL b2b_start got sel=%b tr=%h exp 0010 08", hsel_s, htrans_s); end
        tick(); tick();
        n_cmp++; if (req_ack !== 1'b1 || rd !== 32'h1234_5678) begin n_bad++; $display("FAIL b2b_ack got ack=%b rd=%h exp 1 12345678", req_ack, rd); end
        req = 1'b0;
        tick();
    endtask
    task automatic test_hresp_and_reset();
        hrdata_s[95:64] = 32'h5555_5555; hresp_s[5:4] = 2'b01;
        addr = 32'h2000_0000; size = 2'd2; req = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (req_ack !== 1'b1 || err !== 1'b1 || rd !== 32'h1234_5678) begin n_bad++; $display("FAIL hresp got ack=%b err=%b rd=%h exp 1 1 12345678", req_ack, err, rd); end
        req = 1'b0; hresp_s = '0;
        tick();
        hready_s = 4'b1101; addr = 32'h1000_0000; req = 1'b1;
        tick(); tick();
        n_cmp++; if (hsel_s !== 4'b0010 || hwdata_s[31:0] !== 32'hA5) begin n_bad++; $display("FAIL rstmid_pre got sel=%b wd=%h exp 0010 a5", hsel_s, hwdata_s[31:0]); end
        resetn = 1'b0; req = 1'b0;
        tick();
        n_cmp++; if (hsel_s !== 4'h0 || htrans_s !== 8'h0 || haddr_s !== '0 || hwdata_s !== '0) begin n_bad++; $display("FAIL rstmid_bus got sel=%b a=%h exp 0", hsel_s, haddr_s[31:0]); end
        n_cmp++; if (rd !== 32'h0 || req_ack !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rstmid_core got rd=%h ack=%b err=%b exp 0", rd, req_ack, err); end
        resetn = 1'b1; hready_s = 4'hF;
        tick();
        n_cmp++; if (req_ack !== 1'b0 || hsel_s !== 4'h0) begin n_bad++; $display("FAIL rstmid_noack got ack=%b sel=%b exp 0", req_ack, hsel_s); end
    endtask
    initial begin
        test_reset();
        test_word_read();
        test_byte_write_stall();
        test_default_and_align();
        test_timeout();
        test_back_to_back();
        test_hresp_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
